// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, default handler vector and the
// exception sequencer state encoding.
package cp0_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_TAKE = 2'd2,
        ST_ERET = 2'd3
    } exc_state_e;

    // A victim in a delay slot restarts at its branch so the branch re-executes.
    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
        return bd ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/exc_drain_timer.sv
// Bounded wait for the multiply/divide unit to drain before an exception is taken.
// done rises when busy drops or on the MAX_WAIT-th cycle after start.
module exc_drain_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count;

    // Saturating counter so an idle timer never wraps back into the timeout value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (count != CAP_CNT) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = !busy || (count == LAST_CNT);

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between the M stage, the mul/div unit and CP0:
// picks the winning event, waits for mul/div to drain, then takes it or performs ERET.
module exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
    parameter int          MAX_WAIT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [4:0]  exc_code_m,
    input  logic        int_req,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        eret_m,
    input  logic [31:0] epc_in,
    input  logic        md_busy,
    output logic        hold_pipe,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        exl_set,
    output logic        exl_clr,
    output logic        exc_we,
    output logic [4:0]  exc_code_out,
    output logic [31:0] epc_out,
    output logic        bd_out
);

    exc_state_e  state;
    logic [4:0]  code_r;
    logic [31:0] epc_r;
    logic        bd_r;

    logic        exc_hit;
    logic        eret_hit;
    logic [4:0]  win_code;
    logic [31:0] win_epc;
    logic        start_drain;
    logic        drain_done;
    logic        enter_take;
    logic [4:0]  take_code;
    logic [31:0] take_epc;
    logic        take_bd;

    // Interrupt outranks a synchronous exception, which outranks ERET.
    always_comb begin
        exc_hit     = m_valid && (int_req || (exc_code_m != EXC_INT));
        eret_hit    = m_valid && eret_m && !exc_hit;
        win_code    = int_req ? EXC_INT : exc_code_m;
        win_epc     = victim_epc(pc_m, bd_m);
        start_drain = (state == ST_RUN) && exc_hit;
        enter_take  = ((state == ST_RUN) && exc_hit && !md_busy) ||
                      ((state == ST_WAIT) && drain_done);
        take_code   = (state == ST_RUN) ? win_code : code_r;
        take_epc    = (state == ST_RUN) ? win_epc  : epc_r;
        take_bd     = (state == ST_RUN) ? bd_m     : bd_r;
    end

    exc_drain_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_drain (
        .clk   (clk),
        .reset (reset),
        .start (start_drain),
        .busy  (md_busy),
        .done  (drain_done)
    );

    // Strobes are registered and valid for exactly the cycle spent in TAKE/ERET;
    // the Cause/EPC values only change on entry to TAKE and hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            code_r       <= '0;
            epc_r        <= '0;
            bd_r         <= 1'b0;
            hold_pipe    <= 1'b0;
            flush        <= 1'b0;
            pc_redirect  <= 1'b0;
            exl_set      <= 1'b0;
            exl_clr      <= 1'b0;
            exc_we       <= 1'b0;
            exc_code_out <= '0;
            epc_out      <= '0;
            bd_out       <= 1'b0;
        end else begin
            hold_pipe   <= 1'b0;
            flush       <= 1'b0;
            pc_redirect <= 1'b0;
            exl_set     <= 1'b0;
            exl_clr     <= 1'b0;
            exc_we      <= 1'b0;

            if (start_drain) begin
                code_r <= win_code;
                epc_r  <= win_epc;
                bd_r   <= bd_m;
            end

            if (enter_take) begin
                state        <= ST_TAKE;
                flush        <= 1'b1;
                pc_redirect  <= 1'b1;
                exl_set      <= 1'b1;
                exc_we       <= 1'b1;
                exc_code_out <= take_code;
                epc_out      <= take_epc;
                bd_out       <= take_bd;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (exc_hit) begin
                            state     <= ST_WAIT;
                            hold_pipe <= 1'b1;
                        end else if (eret_hit) begin
                            state       <= ST_ERET;
                            flush       <= 1'b1;
                            pc_redirect <= 1'b1;
                            exl_clr     <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        hold_pipe <= 1'b1;
                    end
                    ST_TAKE, ST_ERET: begin
                        state <= ST_RUN;
                    end
                    default: begin
                        state <= ST_RUN;
                    end
                endcase
            end
        end
    end

    // ERET returns to whatever EPC CP0 holds right now, so it bypasses the registers.
    always_comb begin
        pc_target = '0;
        if (state == ST_TAKE) begin
            pc_target = HANDLER_ADDR;
        end else if (state == ST_ERET) begin
            pc_target = epc_in;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized events
// predicted from the sequencing rules (winner, EPC, number of wait cycles).
module tb_exc_ctrl;

    localparam int          TB_MAX_WAIT = 16;
    localparam logic [31:0] TB_HANDLER  = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic        m_valid;
    logic [4:0]  exc_code_m;
    logic        int_req;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        eret_m;
    logic [31:0] epc_in;
    logic        md_busy;
    logic        hold_pipe;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        exl_set;
    logic        exl_clr;
    logic        exc_we;
    logic [4:0]  exc_code_out;
    logic [31:0] epc_out;
    logic        bd_out;

    int checks = 0;
    int failures = 0;

    logic [4:0]  last_code = '0;
    logic [31:0] last_epc  = '0;
    logic        last_bd   = 1'b0;

    exc_ctrl #(
        .HANDLER_ADDR(TB_HANDLER),
        .MAX_WAIT(TB_MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .exc_code_m   (exc_code_m),
        .int_req      (int_req),
        .pc_m         (pc_m),
        .bd_m         (bd_m),
        .eret_m       (eret_m),
        .epc_in       (epc_in),
        .md_busy      (md_busy),
        .hold_pipe    (hold_pipe),
        .flush        (flush),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .exl_set      (exl_set),
        .exl_clr      (exl_clr),
        .exc_we       (exc_we),
        .exc_code_out (exc_code_out),
        .epc_out      (epc_out),
        .bd_out       (bd_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_idle();
        m_valid    = 1'b0;
        exc_code_m = '0;
        int_req    = 1'b0;
        pc_m       = '0;
        bd_m       = 1'b0;
        eret_m     = 1'b0;
        md_busy    = 1'b0;
    endtask

    task automatic drive_junk();
        m_valid    = 1'($urandom);
        exc_code_m = 5'($urandom);
        int_req    = 1'($urandom);
        eret_m     = 1'($urandom);
        bd_m       = 1'($urandom);
        pc_m       = $urandom;
    endtask

    // One M-stage event from RUN to back in RUN; expectation derived from the rules:
    // interrupt > exception > ERET, EPC backs up 4 in a delay slot, wait = min(busy_len, MAX_WAIT).
    task automatic test_event_sequence(input string name, input logic valid, input logic irq,
                                       input logic [4:0] exc, input logic eret,
                                       input logic [31:0] pc, input logic bd,
                                       input int busy_len, input logic [31:0] epc_val);
        logic        is_exc;
        logic        is_eret;
        logic [4:0]  exp_code;
        logic [31:0] exp_epc;
        logic [31:0] new_epc;
        logic [5:0]  st;
        int          holds;
        is_exc   = valid && (irq || exc != 5'd0);
        is_eret  = valid && eret && !is_exc;
        exp_code = irq ? 5'd0 : exc;
        exp_epc  = bd ? pc - 32'd4 : pc;
        holds    = is_exc ? ((busy_len < TB_MAX_WAIT) ? busy_len : TB_MAX_WAIT) : 0;

        m_valid    = valid;
        int_req    = irq;
        exc_code_m = exc;
        eret_m     = eret;
        pc_m       = pc;
        bd_m       = bd;
        md_busy    = (busy_len > 0);
        epc_in     = epc_val;
        @(posedge clk); #1;

        for (int k = 1; k <= holds; k++) begin
            st = {hold_pipe, flush, pc_redirect, exl_set, exl_clr, exc_we};
            checks++;
            if (st !== 6'b100000) begin
                failures++;
                $display("[TB] FAIL %s wait%0d strobes got=%b exp=%b", name, k, st, 6'b100000);
            end
            checks++;
            if (exc_code_out !== last_code) begin
                failures++;
                $display("[TB] FAIL %s wait%0d code_hold got=%0d exp=%0d", name, k, exc_code_out, last_code);
            end
            drive_junk();
            md_busy = (k < busy_len);
            @(posedge clk); #1;
        end

        st = {hold_pipe, flush, pc_redirect, exl_set, exl_clr, exc_we};
        if (is_exc) begin
            checks++;
            if (st !== 6'b011101) begin
                failures++;
                $display("[TB] FAIL %s take strobes got=%b exp=%b", name, st, 6'b011101);
            end
            checks++;
            if (pc_target !== TB_HANDLER) begin
                failures++;
                $display("[TB] FAIL %s take pc_target got=%h exp=%h", name, pc_target, TB_HANDLER);
            end
            checks++;
            if ({exc_code_out, epc_out, bd_out} !== {exp_code, exp_epc, bd}) begin
                failures++;
                $display("[TB] FAIL %s take capture got=%0d/%h/%b exp=%0d/%h/%b", name,
                         exc_code_out, epc_out, bd_out, exp_code, exp_epc, bd);
            end
            last_code = exp_code;
            last_epc  = exp_epc;
            last_bd   = bd;
        end else if (is_eret) begin
            checks++;
            if (st !== 6'b011010) begin
                failures++;
                $display("[TB] FAIL %s eret strobes got=%b exp=%b", name, st, 6'b011010);
            end
            checks++;
            if (pc_target !== epc_val) begin
                failures++;
                $display("[TB] FAIL %s eret pc_target got=%h exp=%h", name, pc_target, epc_val);
            end
            new_epc = $urandom;
            epc_in  = new_epc;
            #1;
            checks++;
            if (pc_target !== new_epc) begin
                failures++;
                $display("[TB] FAIL %s eret live_epc got=%h exp=%h", name, pc_target, new_epc);
            end
        end else begin
            checks++;
            if (st !== 6'b000000) begin
                failures++;
                $display("[TB] FAIL %s no_event strobes got=%b exp=%b", name, st, 6'b000000);
            end
        end

        if (is_exc || is_eret) begin
            drive_junk();
            @(posedge clk); #1;
            st = {hold_pipe, flush, pc_redirect, exl_set, exl_clr, exc_we};
            checks++;
            if (st !== 6'b000000) begin
                failures++;
                $display("[TB] FAIL %s after strobes got=%b exp=%b", name, st, 6'b000000);
            end
            checks++;
            if ({exc_code_out, epc_out, bd_out} !== {last_code, last_epc, last_bd}) begin
                failures++;
                $display("[TB] FAIL %s after held got=%0d/%h/%b exp=%0d/%h/%b", name,
                         exc_code_out, epc_out, bd_out, last_code, last_epc, last_bd);
            end
        end
        drive_idle();
    endtask

    task automatic test_reset();
        logic [5:0] st;
        drive_idle();
        epc_in = '0;
        reset  = 1'b0;
        #1 reset = 1'b1;
        #1;
        st = {hold_pipe, flush, pc_redirect, exl_set, exl_clr, exc_we};
        checks++;
        if ({st, pc_target, exc_code_out, epc_out, bd_out} !== '0) begin
            failures++;
            $display("[TB] FAIL reset outputs got=%b/%h/%0d/%h/%b exp=0", st, pc_target,
                     exc_code_out, epc_out, bd_out);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        st = {hold_pipe, flush, pc_redirect, exl_set, exl_clr, exc_we};
        checks++;
        if (st !== 6'b000000) begin
            failures++;
            $display("[TB] FAIL reset_release strobes got=%b exp=%b", st, 6'b000000);
        end
    endtask

    task automatic test_directed();
        test_event_sequence("adel_no_drain", 1'b1, 1'b0, 5'd4, 1'b0, 32'h3008, 1'b0, 0, 32'h0);
        test_event_sequence("int_beats_ov_bd", 1'b1, 1'b1, 5'd12, 1'b0, 32'h3010, 1'b1, 0, 32'h0);
        test_event_sequence("drain3", 1'b1, 1'b0, 5'd10, 1'b0, 32'h3020, 1'b0, 3, 32'h0);
        test_event_sequence("timeout", 1'b1, 1'b0, 5'd5, 1'b0, 32'h3024, 1'b1, 1000, 32'h0);
        test_event_sequence("eret_plain", 1'b1, 1'b0, 5'd0, 1'b1, 32'h3030, 1'b0, 2, 32'h3040);
        test_event_sequence("eret_with_int", 1'b1, 1'b1, 5'd0, 1'b1, 32'h3050, 1'b0, 0, 32'h3040);
        test_event_sequence("bubble_ignored", 1'b0, 1'b1, 5'd12, 1'b1, 32'h3060, 1'b0, 0, 32'h0);
        test_event_sequence("pc_wrap_bd", 1'b1, 1'b0, 5'd12, 1'b0, 32'h0000_0002, 1'b1, 15, 32'h0);
    endtask

    task automatic test_reset_mid_wait();
        logic [5:0] st;
        m_valid    = 1'b1;
        exc_code_m = 5'd10;
        int_req    = 1'b0;
        eret_m     = 1'b0;
        pc_m       = 32'h3070;
        bd_m       = 1'b0;
        md_busy    = 1'b1;
        @(posedge clk); #1;
        drive_junk();
        @(posedge clk); #1;
        checks++;
        if (hold_pipe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_wait hold_pipe got=%b exp=1", hold_pipe);
        end
        #2 reset = 1'b1;
        #1;
        st = {hold_pipe, flush, pc_redirect, exl_set, exl_clr, exc_we};
        checks++;
        if ({st, pc_target, exc_code_out, epc_out, bd_out} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_wait_reset outputs got=%b/%h/%0d/%h/%b exp=0", st, pc_target,
                     exc_code_out, epc_out, bd_out);
        end
        last_code = '0;
        last_epc  = '0;
        last_bd   = 1'b0;
        drive_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        test_event_sequence("after_reset", 1'b1, 1'b0, 5'd4, 1'b0, 32'h3080, 1'b1, 2, 32'h0);
    endtask

    task automatic test_random();
        logic [4:0] exc;
        logic [4:0] codes [5];
        codes[0] = 5'd0;
        codes[1] = 5'd4;
        codes[2] = 5'd5;
        codes[3] = 5'd10;
        codes[4] = 5'd12;
        for (int n = 0; n < 40; n++) begin
            exc = ($urandom_range(0, 5) == 5) ? 5'($urandom) : codes[$urandom_range(0, 4)];
            test_event_sequence("random", ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                                exc, 1'($urandom), $urandom, 1'($urandom),
                                int'($urandom_range(0, 20)), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer that sits between the M pipeline stage, the multiply/divide unit and CP0.
- Samples exception and interrupt requests at the M stage and picks the winning event.
- Waits for the multiply/divide unit to drain, then issues one atomic "take" cycle that:
  - drives the CP0 capture signals (EXL set, code, EPC, BD),
  - flushes the pipeline,
  - redirects the PC to the handler.
- Also sequences ERET: clears EXL, flushes, and redirects to EPC.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt handler entry PC
- MAX_WAIT, 16, maximum cycles spent in WAIT before the take is forced (must be ≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m_valid  in  1  M stage holds a real, non-bubble instruction
- exc_code_m  in  5  exception code of the M instruction; 0 means no exception
- int_req  in  1  IntReq from CP0, already masked by IM/IE/EXL
- pc_m  in  32  PC of the M instruction
- bd_m  in  1  M instruction sits in a branch/jump delay slot
- eret_m  in  1  M instruction is ERET
- epc_in  in  32  current EPC read from CP0
- md_busy  in  1  multiply/divide unit has an operation in flight
- hold_pipe  out  1  stall the whole pipeline; active in WAIT
- flush  out  1  clear the F/D/E/M pipeline registers
- pc_redirect  out  1  load pc_target into the PC this cycle
- pc_target  out  32  redirect address
- exl_set  out  1  to CP0 EXLSet
- exl_clr  out  1  to CP0 EXLClr
- exc_we  out  1  CP0 capture strobe for Cause/EPC
- exc_code_out  out  5  ExcCode to write into Cause[6:2]
- epc_out  out  32  value to write into EPC
- bd_out  out  1  value to write into Cause.BD

Behaviour:
- Reset is asynchronous:
  - state goes to RUN;
  - every output is 0, including pc_target and epc_out;
  - the captured registers and the wait counter are 0.
  - Reset asserted mid-WAIT/TAKE/ERET aborts the sequence immediately, with no partial strobe.
- States: RUN, WAIT, TAKE, ERET. Encoding is fixed in the package.
- Event detection happens only in RUN, at a rising edge with m_valid=1. Priority, highest first:
  1. int_req=1: code 0.
  2. exc_code_m≠0: code exc_code_m.
  3. eret_m=1.
- Exception capture at detection, registered:
  - code_r = the winning code;
  - bd_r = bd_m;
  - epc_r = bd_m ? pc_m−4 : pc_m, computed modulo 2^32 with no alignment check.
- Exception transitions:
  - md_busy=0 → TAKE;
  - md_busy=1 → WAIT, with counter=0.
- ERET with no interrupt and no exception → ERET.
- An ERET that coincides with an interrupt or exception is treated as that exception. Its EPC is the ERET's own PC, or PC−4 when bd_m=1.
- WAIT:
  - hold_pipe=1; the counter increments each cycle.
  - Go to TAKE on the first cycle with md_busy=0 or counter==MAX_WAIT−1.
  - WAIT therefore lasts at most MAX_WAIT cycles.
  - Counter width is clog2(MAX_WAIT+1).
- TAKE lasts exactly 1 cycle, then returns to RUN. During it:
  - flush=1, pc_redirect=1, pc_target=HANDLER_ADDR;
  - exl_set=1, exc_we=1;
  - exc_code_out=code_r, epc_out=epc_r, bd_out=bd_r.
- ERET lasts exactly 1 cycle, then returns to RUN. During it:
  - flush=1, pc_redirect=1, exl_clr=1;
  - pc_target=epc_in, sampled in this cycle, so a CP0 write committed the cycle before is honoured.
- Outside TAKE/ERET, every strobe is 0. exc_code_out, epc_out and bd_out hold their last values.
- Events presented in WAIT, TAKE or ERET are ignored. The flush removes them, and the instruction re-executes after return.
- exl_set and exl_clr are never both 1.

Decomposition:
- Package cp0_pkg:
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12;
  - default HANDLER_ADDR;
  - state encoding for RUN, WAIT, TAKE, ERET.
- One natural sub-module, exc_drain_timer:
  - inputs: start, busy;
  - output: done, asserted on busy low or timeout;
  - parameterised by MAX_WAIT.
- The FSM, priority logic and EPC computation stay in exc_ctrl.

Test Plan:
- AdEL, no drain. m_valid=1, exc_code_m=4, pc_m=0x3008, bd_m=0, md_busy=0 → the next cycle alone has flush=pc_redirect=exl_set=exc_we=1, pc_target=0x4180, exc_code_out=4, epc_out=0x3008, bd_out=0; the cycle after is back in RUN with all strobes 0.
- Interrupt beats exception in a delay slot. int_req=1, exc_code_m=12, pc_m=0x3010, bd_m=1 → TAKE with exc_code_out=0, epc_out=0x300C, bd_out=1.
- Drain. Exception while md_busy=1 for 3 more cycles → hold_pipe=1 for exactly 3 cycles, TAKE in the 4th, with no flush before it.
- Timeout. md_busy stuck at 1, MAX_WAIT=16 → exactly 16 hold_pipe cycles, then TAKE.
- ERET:
  - Plain case: eret_m=1, epc_in=0x3040 → one cycle with exl_clr=flush=pc_redirect=1, pc_target=0x3040, exc_we=0.
  - ERET plus int_req at pc_m=0x3050 → TAKE with epc_out=0x3050, code 0, exl_clr=0.
- Reset mid-WAIT. reset pulsed while in WAIT → all outputs 0 asynchronously, before the next edge. After release, a new exception is taken normally.
